serial_to_parallel_receiver: RTL and testbench
==============================================

// Module: serial_to_parallel_receiver
//
// PURPOSE
//   Receive end of the serial link driven by the parallel-to-serial sender.
//   Hunts the incoming bit stream for a sync word to find word alignment, then
//   deserialises MSB-first WIDTH-bit words and presents each one as a
//   single-cycle parallel strobe.
//   Sits between the serial line model and the parallel datapath.
//
// PARAMETERS
//   WIDTH      8      data word width in bits; SYNC_WORD is also WIDTH bits
//   SYNC_WORD  8'hBC  alignment pattern (K28.5-style comma)
//
// PORTS
//   clock           in   1      single system clock, rising edge
//   reset           in   1      synchronous, active-high
//   serial_in       in   1      serial data bit, MSB first
//   receive_enable  in   1      1 = serial_in carries a valid bit this cycle
//   data_out        out  WIDTH  last received word; held between strobes
//   data_valid      out  1      1-cycle pulse, data_out is new
//   aligned         out  1      1 = locked to word boundary
//   parity_error    out  1      1-cycle pulse with data_valid (see CONFIG)
//
// BEHAVIOUR
//   - Reset (sampled at a rising edge): state=HUNT, shift window=0, bit_count=0,
//     data_out=0, data_valid=0, aligned=0, parity_error=0.
//     Reset wins over every other input, including mid-word.
//   - A bit is sampled only on a rising edge with receive_enable=1.
//   - HUNT: each sampled bit is shifted into the LSB of a WIDTH-bit window.
//     If the window after the shift equals SYNC_WORD, then on that same edge:
//     state=LOCKED, aligned=1, bit_count=0. No data_valid is issued for the
//     sync word. Any bit offset before the sync word is tolerated.
//   - LOCKED: bits accumulate MSB first and bit_count increments.
//     On the edge that samples the last bit of a frame (bit_count = FRAME-1):
//       * if the word != SYNC_WORD: data_out<=word and data_valid<=1
//         (visible the following cycle, high for exactly 1 cycle);
//       * if the word == SYNC_WORD: the word is dropped (re-sync), no strobe,
//         aligned stays 1;
//       * bit_count wraps to 0; the next bit starts a new frame without a gap.
//   - FRAME = WIDTH, or WIDTH+1 with parity enabled.
//   - receive_enable low while LOCKED, at any bit position (including 0):
//     next edge state=HUNT, aligned=0, window=0, bit_count=0. The partial word
//     is discarded. data_out keeps its last value.
//   - receive_enable low in HUNT: state and window hold.
//   - data_valid and parity_error are 0 in every cycle without a strobe.
//
// CONFIGURATION
//   S2P_PARITY_EN defined: in LOCKED, each frame is WIDTH data bits followed
//     by one even-parity bit (XOR of data bits ^ parity bit must be 0).
//     On a mismatch, parity_error pulses together with data_valid; the word
//     is still delivered. The parity bit of a sync-word frame is ignored.
//     The HUNT window carries no parity.
//   S2P_PARITY_EN undefined: FRAME = WIDTH, no parity logic; the
//     parity_error port is present and tied 0.
//
// TESTING
//   1. reset=1 for 2 cycles with serial_in toggling -> data_out=0,
//      data_valid=0, aligned=0.
//   2. Bits 1,0,1 then 0xBC then 0xA5, with enable high -> aligned=1 from the
//      edge that samples the last sync bit; 8 cycles later data_valid=1 for
//      1 cycle with data_out=8'hA5.
//   3. While locked, send 0xBC then 0x3C -> no strobe for 0xBC, aligned stays 1;
//      single strobe with data_out=8'h3C.
//   4. While locked, send 4 bits of 0xF0, then enable=0 for 1 cycle, then 0xF0
//      -> aligned=0 and no strobe; the next strobe requires a fresh 0xBC.
//   5. While locked, assert reset after 5 bits of a word -> the next cycle
//      shows all outputs 0 and HUNT; the remaining 3 bits produce no strobe.
//   6. With S2P_PARITY_EN: send 0xA5 with parity bit 1 -> data_valid=1,
//      data_out=8'hA5, parity_error=1. Send 0xA5 with parity bit 0 ->
//      parity_error=0.

Source files
------------

// File: rtl/serial_to_parallel_receiver.sv
// Serial receiver: hunts for SYNC_WORD, then deserialises MSB-first words; data_valid pulses the cycle after a frame's last bit.
// No backpressure (bits arrive when receive_enable=1); optional even parity bit per frame via `define S2P_PARITY_EN.
module serial_to_parallel_receiver #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] SYNC_WORD = 8'hBC
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             receive_enable,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             aligned,
  output logic             parity_error
);

`ifdef S2P_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = (FRAME > 1) ? $clog2(FRAME) : 1;

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] window, window_nxt;
  logic [CW-1:0]    bit_count, count_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic             valid_nxt;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word;
`ifdef S2P_PARITY_EN
  logic             perr_nxt;
`endif

  assign shifted = {window[WIDTH-2:0], serial_in};
  assign aligned = (state == LOCKED);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= HUNT;
      window     <= '0;
      bit_count  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
`ifdef S2P_PARITY_EN
      parity_error <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      window     <= window_nxt;
      bit_count  <= count_nxt;
      data_out   <= data_nxt;
      data_valid <= valid_nxt;
`ifdef S2P_PARITY_EN
      parity_error <= perr_nxt;
`endif
    end
  end

`ifndef S2P_PARITY_EN
  assign parity_error = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    window_nxt = window;
    count_nxt  = bit_count;
    data_nxt   = data_out;
    valid_nxt  = 1'b0;
    word       = '0;
`ifdef S2P_PARITY_EN
    perr_nxt   = 1'b0;
`endif
    case (state)
      HUNT: begin
        if (receive_enable) begin
          window_nxt = shifted;
          if (shifted == SYNC_WORD) begin
            state_nxt = LOCKED;
            count_nxt = '0;
          end
        end
      end
      LOCKED: begin
        if (!receive_enable) begin
          state_nxt  = HUNT;
          window_nxt = '0;
          count_nxt  = '0;
        end else if (bit_count == CW'(FRAME - 1)) begin
          count_nxt = '0;
`ifdef S2P_PARITY_EN
          // window already holds all data bits; serial_in is the parity bit
          word = window;
`else
          word       = shifted;
          window_nxt = shifted;
`endif
          if (word != SYNC_WORD) begin
            data_nxt  = word;
            valid_nxt = 1'b1;
`ifdef S2P_PARITY_EN
            perr_nxt  = (^window) ^ serial_in;
`endif
          end
        end else begin
          count_nxt  = bit_count + CW'(1);
          window_nxt = shifted;
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

endmodule

// File: tb/tb_serial_to_parallel_receiver.sv
// Randomised and directed bench for serial_to_parallel_receiver against a queue-based frame model.
module tb_serial_to_parallel_receiver;
  localparam int WIDTH = 8;
  localparam logic [7:0] SYNC = 8'hBC;
`ifdef S2P_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       serial_in = 1'b0;
  logic       receive_enable = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       aligned;
  logic       parity_error;

  serial_to_parallel_receiver #(.WIDTH(WIDTH), .SYNC_WORD(SYNC)) dut (
    .clock(clock), .reset(reset), .serial_in(serial_in),
    .receive_enable(receive_enable), .data_out(data_out),
    .data_valid(data_valid), .aligned(aligned), .parity_error(parity_error)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit       m_locked = 0;
  int       m_hist = 0;
  bit       m_frame[$];
  int       m_data = 0;
  bit       m_valid = 0;
  bit       m_perr = 0;
  int       m_strobes = 0;

  // observed strobe history
  int         dut_strobes = 0;
  logic [7:0] last_data = '0;
  logic       last_perr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit b);
    int w;
    bit p;
    m_valid = 0;
    m_perr  = 0;
    if (r) begin
      m_locked = 0; m_hist = 0; m_frame.delete(); m_data = 0;
    end else if (!m_locked) begin
      if (e) begin
        m_hist = ((m_hist << 1) | int'(b)) & 'hFF;
        if (m_hist == int'(SYNC)) begin
          m_locked = 1;
          m_frame.delete();
        end
      end
    end else if (!e) begin
      m_locked = 0; m_hist = 0; m_frame.delete();
    end else begin
      m_frame.push_back(b);
      if (m_frame.size() == FRAME) begin
        w = 0;
        p = 0;
        for (int i = 0; i < WIDTH; i++) w = (w << 1) | int'(m_frame[i]);
        foreach (m_frame[i]) p ^= m_frame[i];
        if (w != int'(SYNC)) begin
          m_data  = w;
          m_valid = 1;
          m_strobes++;
`ifdef S2P_PARITY_EN
          m_perr  = p;
`endif
        end
        m_frame.delete();
      end
    end
  endtask

  task automatic cycle(input bit r, input bit e, input bit b);
    reset = r; receive_enable = e; serial_in = b;
    @(posedge clock);
    model_step(r, e, b);
    #1;
    check("data_out", 32'(data_out), 32'(m_data));
    check("data_valid", 32'(data_valid), 32'(m_valid));
    check("aligned", 32'(aligned), 32'(m_locked));
    check("parity_error", 32'(parity_error), 32'(m_perr));
    if (data_valid === 1'b1) begin
      dut_strobes++;
      last_data = data_out;
      last_perr = parity_error;
    end
  endtask

  // raw 8 bits with no parity slot, used while hunting
  task automatic send_raw(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) cycle(0, 1, w[i]);
  endtask

  // one locked frame; flip=1 sends the wrong parity bit
  task automatic send_word(input logic [7:0] w, input bit flip);
    send_raw(w);
`ifdef S2P_PARITY_EN
    cycle(0, 1, (^w) ^ flip);
`else
    if (flip) begin end
`endif
  endtask

  int         s0;
  logic [7:0] rw;
  int         sel;

  initial begin
    // 1: reset with toggling data
    cycle(1, 1, 1);
    cycle(1, 0, 0);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_aligned", 32'(aligned), 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);

    // 2: offset bits, sync, first word
    cycle(0, 1, 1); cycle(0, 1, 0); cycle(0, 1, 1);
    send_raw(SYNC);
    check("lock_after_sync", 32'(aligned), 32'h1);
    s0 = dut_strobes;
    send_word(8'hA5, 0);
    check("a5_strobes", 32'(dut_strobes - s0), 32'd1);
    check("a5_data", 32'(last_data), 32'hA5);

    // 3: in-band sync is dropped
    s0 = dut_strobes;
    send_word(SYNC, 0);
    check("resync_no_strobe", 32'(dut_strobes - s0), 32'd0);
    check("resync_aligned", 32'(aligned), 32'h1);
    send_word(8'h3C, 0);
    check("3c_strobes", 32'(dut_strobes - s0), 32'd1);
    check("3c_data", 32'(last_data), 32'h3C);

    // 4: enable drop mid-word loses lock
    s0 = dut_strobes;
    for (int i = 0; i < 4; i++) cycle(0, 1, 1);
    cycle(0, 0, 0);
    check("drop_unlock", 32'(aligned), 32'h0);
    send_word(8'hF0, 0);
    check("drop_no_strobe", 32'(dut_strobes - s0), 32'd0);
    check("drop_still_hunt", 32'(aligned), 32'h0);

    // 5: reset mid-word
    send_raw(SYNC);
    s0 = dut_strobes;
    for (int i = 0; i < 5; i++) cycle(0, 1, i[0]);
    cycle(1, 1, 1);
    check("midrst_aligned", 32'(aligned), 32'h0);
    check("midrst_data", 32'(data_out), 32'h0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1);
    check("midrst_no_strobe", 32'(dut_strobes - s0), 32'd0);

`ifdef S2P_PARITY_EN
    // 6: parity
    send_raw(SYNC);
    send_word(8'hA5, 1);
    check("par_bad_data", 32'(last_data), 32'hA5);
    check("par_bad_flag", 32'(last_perr), 32'h1);
    send_word(8'hA5, 0);
    check("par_good_flag", 32'(last_perr), 32'h0);
`endif

    // randomised stream
    for (int it = 0; it < 300; it++) begin
      sel = $urandom_range(0, 99);
      if (sel < 3) begin
        cycle(1, $urandom_range(0, 1), $urandom_range(0, 1));
      end else if (sel < 10) begin
        for (int k = 0; k < $urandom_range(1, 5); k++)
          cycle(0, $urandom_range(0, 3) != 0, $urandom_range(0, 1));
      end else if (sel < 25) begin
        send_raw(SYNC);
      end else begin
        rw = 8'($urandom);
        if ($urandom_range(0, 9) == 0) rw = SYNC;
        for (int i = 7; i >= 0; i--) cycle(0, $urandom_range(0, 49) != 0, rw[i]);
`ifdef S2P_PARITY_EN
        cycle(0, 1, (^rw) ^ ($urandom_range(0, 3) == 0));
`endif
      end
    end
    check("total_strobes", 32'(dut_strobes), 32'(m_strobes));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
